uart_tx_sched: RTL
==================

# uart_tx_sched

Two-requester UART transmit scheduler and frame sequencer. It arbitrates round-robin between two byte sources for one serial TX line and serializes each accepted byte. It sits downstream of the fixed baud generator and consumes its oversample strobe (16× bit rate; N=27 at 50 MHz / 115200). It owns the TX pin for the command/data system.

## Interface

Parameters:
- DATA_BITS, 8: payload bits per frame.
- OVERSAMPLE, 16: `tick` strobes per bit period.
- STOP_BITS, 1: number of stop bits; only 1 or 2 is legal.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `tick`, in, 1: oversample strobe from the baud generator; one `clk` wide.
- `req_valid`, in, 2: per-requester "byte available".
- `req_data`, in, 2*DATA_BITS: requester i occupies bits [i*DATA_BITS +: DATA_BITS].
- `req_ready`, out, 2: one-cycle acceptance pulse, one-hot or zero.
- `tx`, out, 1: serial line; idles high.
- `busy`, out, 1: high while a frame is in progress.
- `grant_id`, out, 1: index of the requester that was last accepted.

## Operation

- States: IDLE, START, DATA, PARITY (only when the parity macro is defined), STOP.
- IDLE:
  - `tx`=1.
  - If any `req_valid` bit is high, grant one requester, pulse its `req_ready`, latch its data into the shift register, set `grant_id`, clear the counters, and go to START.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: the requester other than `grant_id` wins.
  - After reset, requester 0 wins a tie.
- Handshake:
  - A requester holds valid and data stable until it sees ready.
  - Dropping valid before ready is legal and has no effect.
  - Ready is never asserted outside IDLE.
- Bit timing:
  - `os_cnt` (width clog2(OVERSAMPLE)) increments on each `tick`.
  - A bit ends on a `tick` that arrives while `os_cnt`==OVERSAMPLE-1. On that tick, `os_cnt` wraps to 0 and the state advances.
- Frame sequence:
  - START: `tx`=0 for one bit period.
  - DATA: DATA_BITS bits, LSB first. `bit_cnt` has width clog2(DATA_BITS+1) and the shift register moves right once per bit.
  - PARITY (when enabled): one bit period.
  - STOP: `tx`=1 for STOP_BITS bit periods, then return to IDLE.
- `tx` is registered.
- `busy` = (state != IDLE).

## Timing

- Reset values: `tx`=1, `busy`=0, `req_ready`=0, `grant_id`=0, state=IDLE, counters=0. Reset takes effect asynchronously at any point, including mid-frame. The partial frame is discarded and is not replayed.
- Acceptance edge E:
  - `req_ready` is high during the cycle before E.
  - `tx` falls and `busy` rises in the cycle after E.
- Frame length:
  - Exactly (1 + DATA_BITS + P + STOP_BITS) × OVERSAMPLE ticks, where P is 1 with parity enabled and 0 otherwise.
  - This is counted from the first `tick` strictly after E.
  - A `tick` coincident with acceptance is not counted.
- The state returns to IDLE on the final STOP tick. The earliest next acceptance is the following `clk`, so there is no idle bit between back-to-back frames.
- `tick` in IDLE is ignored.
- `req_valid` changes during a frame are ignored until IDLE.

## Configuration

- Macro: `UART_TX_PARITY_EN`.
- Defined: a PARITY state is inserted after DATA. It transmits even parity, the XOR of the data bits.
- Undefined: no PARITY state, and DATA goes directly to STOP.

## Structure

- Package `uart_pkg` holds:
  - the state enum `tx_state_t`;
  - the default constants `UART_OVERSAMPLE`=16 and `UART_DATA_BITS`=8;
  - a shared `clog2` function.
- Sub-module `rr_arb2`: a combinational 2-way round-robin grant from `req_valid` and the last-grant bit. The pointer register stays in the parent.

## Test plan

- Single frame: req0 sends 0xA5 with parity disabled. `tx` must be 0,1,0,1,0,0,1,0,1,1, each level held exactly 16 ticks. `busy` must be high for 160 ticks.
- Tie after reset: req0=0x11 and req1=0x22 are valid simultaneously. 0x11 is sent first with `grant_id`=0, then 0x22 with `grant_id`=1. The second `req_ready` must fire one `clk` after the first frame's final tick.
- Fairness: both requesters are held valid continuously for 4 frames. Grants must alternate 0,1,0,1.
- Parity: with `UART_TX_PARITY_EN` defined, send 0x07. The parity bit must be 1 and the frame must last 176 ticks.
- Reset mid-frame: assert `rst_n`=0 during DATA bit 3. `tx`=1 and `busy`=0 immediately. After release, a new request is sent as a complete, clean frame.
- STOP_BITS=2: send 0xFF. The line must be high for 32 ticks after the last data bit before the next start bit.

Source files
------------

// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_pkg : shared types, default constants and helpers for the UART TX path |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >>> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_tx_sched_rr_arb2.sv
// +----------------------------------------------------------------------------+
// | rr_arb2 : combinational two-way round-robin grant                            |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic [1:0] o_grant,
  output logic       o_grant_idx
);

  // i_prio names the requester that wins when both are asserting.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_prio ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

  assign o_grant_idx = o_grant[1];

endmodule : rr_arb2

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// +----------------------------------------------------------------------------+
// | uart_tx_sched : two-requester round-robin UART transmit scheduler/framer    |
// | Optional even parity bit when UART_TX_PARITY_EN is defined.                 |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic [1:0]             req_valid,
  input  logic [2*DATA_BITS-1:0] req_data,
  output logic [1:0]             req_ready,
  output logic                   tx,
  output logic                   busy,
  output logic                   grant_id
);

  localparam int OS_W = (clog2(OVERSAMPLE) < 1) ? 1 : clog2(OVERSAMPLE);
  localparam int BC_W = clog2(DATA_BITS + 1);

  localparam logic [OS_W-1:0] OS_LAST        = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_DATA_LAST   = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0] BC_STOP_LAST   = BC_W'(STOP_BITS - 1);

  tx_state_t              r_state;
  logic [OS_W-1:0]        r_os_cnt;
  logic [BC_W-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_tx;
  logic                   r_grant_id;
  logic                   r_prio;
`ifdef UART_TX_PARITY_EN
  logic                   r_parity;
`endif

  logic [1:0]             w_grant;
  logic                   w_grant_idx;
  logic                   w_bit_end;
  logic [DATA_BITS-1:0]   w_sel_data;
  logic [DATA_BITS-1:0]   w_shift_next;

  rr_arb2 u_arb (
    .i_req       (req_valid),
    .i_prio      (r_prio),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign w_bit_end    = tick && (r_os_cnt == OS_LAST);
  assign w_sel_data   = w_grant_idx ? req_data[DATA_BITS +: DATA_BITS]
                                    : req_data[0 +: DATA_BITS];
  assign w_shift_next = r_shift >> 1;

  // Acceptance is decided in the same cycle the grant is offered.
  assign req_ready = (rst_n && (r_state == ST_IDLE)) ? w_grant : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_os_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_grant_id <= 1'b0;
      r_prio     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      if ((r_state != ST_IDLE) && tick) begin
        r_os_cnt <= w_bit_end ? '0 : r_os_cnt + OS_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (|req_valid) begin
            r_state    <= ST_START;
            r_shift    <= w_sel_data;
            r_grant_id <= w_grant_idx;
            r_prio     <= ~w_grant_idx;
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= ^w_sel_data;
`endif
          end
        end

        ST_START: begin
          if (w_bit_end) begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end
        end

        ST_DATA: begin
          if (w_bit_end) begin
            r_shift <= w_shift_next;
            if (r_bit_cnt == BC_DATA_LAST) begin
              r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              r_state   <= ST_PARITY;
              r_tx      <= r_parity;
`else
              r_state   <= ST_STOP;
              r_tx      <= 1'b1;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + BC_W'(1);
              r_tx      <= w_shift_next[0];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif

        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            if (r_bit_cnt == BC_STOP_LAST) begin
              r_state   <= ST_IDLE;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + BC_W'(1);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign busy     = (r_state != ST_IDLE);
  assign grant_id = r_grant_id;

endmodule : uart_tx_sched

`default_nettype wire
